seq_divider: RTL and testbench

- Parametrised multi-cycle restoring divider; successor to the single-step subtract/compare ALU function (Funct 6'b001010).
- Iterates one quotient bit per clock internally; adds signed mode, divide-by-zero handling and a start/busy/done handshake.
- Sits beside the ALU in the datapath; the controller launches it and stalls until done.

---
 rtl/div_pkg.sv | 34 +++
 rtl/div_step.sv | 32 +++
 rtl/seq_divider.sv | 163 ++++++++++++++++
 tb/tb_seq_divider.sv | 182 ++++++++++++++++++
 4 files changed

// File: rtl/div_pkg.sv
// Shared definitions for the sequential divider: FSM encodings, mode
// constants and a magnitude helper usable at any operand width.
package div_pkg;

  // FSM encodings, kept as plain constants so they match older netlists
  typedef logic [1:0] state_t;
  localparam state_t IDLE = 2'd0;
  localparam state_t CALC = 2'd1;
  localparam state_t FIX  = 2'd2;

  // Operand interpretation selected by signed_mode
  localparam logic MODE_UNSIGNED = 1'b0;
  localparam logic MODE_SIGNED   = 1'b1;

  // Widest operand the magnitude helper supports
  localparam int ABS_MAX_W = 64;

  // Magnitude of a w-bit two's-complement value carried zero-extended in a
  // ABS_MAX_W-bit container. The low w bits of the result hold the answer;
  // the most-negative value maps onto itself, which the divider relies on.
  function automatic logic [ABS_MAX_W-1:0] abs_val(
    input logic [ABS_MAX_W-1:0] v,
    input int unsigned          w
  );
    logic [ABS_MAX_W-1:0] sign_mask;
    sign_mask = {{(ABS_MAX_W-1){1'b0}}, 1'b1} << (w - 32'd1);
    if ((v & sign_mask) != {ABS_MAX_W{1'b0}}) begin
      return {ABS_MAX_W{1'b0}} - v;
    end else begin
      return v;
    end
  endfunction

endpackage

// File: rtl/div_step.sv
// One restoring-division iteration: shift {rem, quo} left, try to subtract
// the divisor, and keep the difference only when it does not borrow.
module div_step
  import div_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] rem,
  input  logic [WIDTH-1:0] quo,
  input  logic [WIDTH-1:0] div,
  output logic [WIDTH-1:0] next_rem,
  output logic [WIDTH-1:0] next_quo
);

  logic [WIDTH:0]   shifted_s;
  logic [WIDTH+1:0] diff_s;
  logic             borrow_s;

  // Shift/trial-subtract/restore; the extra top bit of diff_s is the borrow
  always_comb begin
    shifted_s = {rem, quo[WIDTH-1]};
    diff_s    = {1'b0, shifted_s} - {2'b00, div};
    borrow_s  = diff_s[WIDTH+1];
    if (borrow_s) begin
      next_rem = WIDTH'(shifted_s);
    end else begin
      next_rem = WIDTH'(diff_s);
    end
    next_quo = {quo[WIDTH-2:0], ~borrow_s};
  end

endmodule

// File: rtl/seq_divider.sv
// Multi-cycle restoring divider with unsigned/signed modes, divide-by-zero
// short-cut and a start/busy/done handshake. One quotient bit per clock.
module seq_divider
  import div_pkg::*;
#(
  parameter  int WIDTH = 32,
  localparam int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             signed_mode,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] rem_q, rem_d;
  logic [WIDTH-1:0] quo_q, quo_d;
  logic [WIDTH-1:0] div_q, div_d;
  logic             q_neg_q, q_neg_d;
  logic             r_neg_q, r_neg_d;
  logic             dz_q, dz_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic [WIDTH-1:0] quotient_q, quotient_d;
  logic [WIDTH-1:0] remainder_q, remainder_d;
  logic             dbz_q, dbz_d;

  logic [WIDTH-1:0] step_rem_s;
  logic [WIDTH-1:0] step_quo_s;

  div_step #(.WIDTH(WIDTH)) u_step (
    .rem      (rem_q),
    .quo      (quo_q),
    .div      (div_q),
    .next_rem (step_rem_s),
    .next_quo (step_quo_s)
  );

  // Next-state logic: launch capture, iteration and sign fix-up
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    rem_d       = rem_q;
    quo_d       = quo_q;
    div_d       = div_q;
    q_neg_d     = q_neg_q;
    r_neg_d     = r_neg_q;
    dz_d        = dz_q;
    busy_d      = busy_q;
    done_d      = 1'b0;
    quotient_d  = quotient_q;
    remainder_d = remainder_q;
    dbz_d       = dbz_q;

    case (state_q)
      IDLE: begin
        if (start) begin
          busy_d = 1'b1;
          rem_d  = {WIDTH{1'b0}};
          if (signed_mode == MODE_SIGNED) begin
            quo_d   = WIDTH'(abs_val(ABS_MAX_W'(dividend), WIDTH));
            div_d   = WIDTH'(abs_val(ABS_MAX_W'(divisor), WIDTH));
            q_neg_d = dividend[WIDTH-1] ^ divisor[WIDTH-1];
            r_neg_d = dividend[WIDTH-1];
          end else begin
            quo_d   = dividend;
            div_d   = divisor;
            q_neg_d = 1'b0;
            r_neg_d = 1'b0;
          end
          if (divisor == {WIDTH{1'b0}}) begin
            // Zero divisor: keep the raw dividend for the remainder output
            dz_d    = 1'b1;
            rem_d   = dividend;
            cnt_d   = {CNT_W{1'b0}};
            state_d = FIX;
          end else begin
            dz_d    = 1'b0;
            cnt_d   = CNT_W'(WIDTH);
            state_d = CALC;
          end
        end else begin
          state_d = IDLE;
        end
      end
      CALC: begin
        rem_d = step_rem_s;
        quo_d = step_quo_s;
        cnt_d = cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) begin
          state_d = FIX;
        end else begin
          state_d = CALC;
        end
      end
      FIX: begin
        state_d = IDLE;
        busy_d  = 1'b0;
        done_d  = 1'b1;
        dbz_d   = dz_q;
        if (dz_q) begin
          quotient_d  = {WIDTH{1'b1}};
          remainder_d = rem_q;
        end else begin
          quotient_d  = q_neg_q ? ({WIDTH{1'b0}} - quo_q) : quo_q;
          remainder_d = r_neg_q ? ({WIDTH{1'b0}} - rem_q) : rem_q;
        end
      end
      default: begin
        state_d = IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  // State and result registers; reset aborts any division in flight
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      cnt_q       <= {CNT_W{1'b0}};
      rem_q       <= {WIDTH{1'b0}};
      quo_q       <= {WIDTH{1'b0}};
      div_q       <= {WIDTH{1'b0}};
      q_neg_q     <= 1'b0;
      r_neg_q     <= 1'b0;
      dz_q        <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      quotient_q  <= {WIDTH{1'b0}};
      remainder_q <= {WIDTH{1'b0}};
      dbz_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      rem_q       <= rem_d;
      quo_q       <= quo_d;
      div_q       <= div_d;
      q_neg_q     <= q_neg_d;
      r_neg_q     <= r_neg_d;
      dz_q        <= dz_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      quotient_q  <= quotient_d;
      remainder_q <= remainder_d;
      dbz_q       <= dbz_d;
    end
  end

  assign busy        = busy_q;
  assign done        = done_q;
  assign quotient    = quotient_q;
  assign remainder   = remainder_q;
  assign div_by_zero = dbz_q;

endmodule

// File: tb/tb_seq_divider.sv
// Directed bench for seq_divider: a 32-bit and an 8-bit instance share the
// clock and reset; expected values below are worked out by hand.
module tb_seq_divider;

  logic        clk;
  logic        rst;
  logic        start32, start8;
  logic        sm_in;
  logic [31:0] a_in, b_in;
  logic        sel8;

  logic        busy32, done32, dbz32;
  logic [31:0] q32, r32;
  logic        busy8, done8, dbz8;
  logic [7:0]  q8, r8;

  logic        busy_o, done_o, dbz_o;
  logic [31:0] q_o, r_o;

  int total = 0;
  int bad   = 0;

  seq_divider #(.WIDTH(32)) u_d32 (
    .clk(clk), .rst(rst), .start(start32), .signed_mode(sm_in),
    .dividend(a_in), .divisor(b_in), .busy(busy32), .done(done32),
    .quotient(q32), .remainder(r32), .div_by_zero(dbz32)
  );

  seq_divider #(.WIDTH(8)) u_d8 (
    .clk(clk), .rst(rst), .start(start8), .signed_mode(sm_in),
    .dividend(a_in[7:0]), .divisor(b_in[7:0]), .busy(busy8), .done(done8),
    .quotient(q8), .remainder(r8), .div_by_zero(dbz8)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Observe whichever instance is under test
  always_comb begin
    if (sel8) begin
      busy_o = busy8; done_o = done8; dbz_o = dbz8;
      q_o = {24'd0, q8}; r_o = {24'd0, r8};
    end else begin
      busy_o = busy32; done_o = done32; dbz_o = dbz32;
      q_o = q32; r_o = r32;
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Present operands and pulse start for one cycle (accepted at the next posedge)
  task automatic launch(input logic w8, input logic sm, input logic [31:0] a, input logic [31:0] b);
    @(negedge clk);
    sel8 = w8; sm_in = sm; a_in = a; b_in = b;
    if (w8) start8 = 1'b1; else start32 = 1'b1;
    @(negedge clk);
    start8 = 1'b0; start32 = 1'b0;
  endtask

  // Count cycles from the launch edge until done, bounded
  task automatic wait_done(inout int k);
    while (done_o !== 1'b1 && k < 200) begin
      @(negedge clk);
      k++;
    end
  endtask

  task automatic run(input string tag, input logic w8, input logic sm,
                     input logic [31:0] a, input logic [31:0] b,
                     input logic [31:0] eq, input logic [31:0] er,
                     input logic edz, input int lat);
    int k;
    launch(w8, sm, a, b);
    k = 0;
    check({tag, ".busy_after_launch"}, {31'd0, busy_o}, 32'd1);
    wait_done(k);
    check({tag, ".latency"}, k, lat);
    check({tag, ".busy_in_done"}, {31'd0, busy_o}, 32'd0);
    check({tag, ".quotient"}, q_o, eq);
    check({tag, ".remainder"}, r_o, er);
    check({tag, ".dbz"}, {31'd0, dbz_o}, {31'd0, edz});
    @(negedge clk);
    check({tag, ".done_single"}, {31'd0, done_o}, 32'd0);
  endtask

  initial begin
    int k;
    int seen;
    rst = 1'b1; start32 = 1'b0; start8 = 1'b0; sm_in = 1'b0;
    a_in = 32'd0; b_in = 32'd0; sel8 = 1'b0;
    repeat (2) @(negedge clk);

    check("rst32.outs", {busy32, done32, dbz32}, 32'd0);
    check("rst32.q", q32, 32'd0);
    check("rst32.r", r32, 32'd0);
    check("rst8.outs", {busy8, done8, dbz8, q8, r8}, 32'd0);
    rst = 1'b0;

    // 32-bit cases
    run("u100_7",   1'b0, 1'b0, 32'd100, 32'd7, 32'd14, 32'd2, 1'b0, 33);
    run("s-100_7",  1'b0, 1'b1, 32'hFFFF_FF9C, 32'd7, 32'hFFFF_FFF2, 32'hFFFF_FFFE, 1'b0, 33);
    run("s100_-7",  1'b0, 1'b1, 32'd100, 32'hFFFF_FFF9, 32'hFFFF_FFF2, 32'd2, 1'b0, 33);
    run("dz1234",   1'b0, 1'b0, 32'h1234, 32'd0, 32'hFFFF_FFFF, 32'h1234, 1'b1, 1);
    run("dzneg",    1'b0, 1'b1, 32'hFFFF_FF9C, 32'd0, 32'hFFFF_FFFF, 32'hFFFF_FF9C, 1'b1, 1);
    run("uFFFF_16", 1'b0, 1'b0, 32'hFFFF_FFFF, 32'h10, 32'h0FFF_FFFF, 32'hF, 1'b0, 33);
    run("s_min_m1", 1'b0, 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 32'd0, 1'b0, 33);

    // 8-bit cases
    run("w8s80_FF", 1'b1, 1'b1, 32'h80, 32'hFF, 32'h80, 32'h00, 1'b0, 9);
    run("w8uFF_01", 1'b1, 1'b0, 32'hFF, 32'h01, 32'hFF, 32'h00, 1'b0, 9);
    run("w8s-7_2",  1'b1, 1'b1, 32'hF9, 32'h02, 32'hFD, 32'hFF, 1'b0, 9);

    // Start while busy is ignored: the first division completes untouched
    launch(1'b0, 1'b0, 32'd1000, 32'd3);
    k = 0;
    while (k < 5) begin @(negedge clk); k++; end
    a_in = 32'd77; b_in = 32'd5; start32 = 1'b1;
    @(negedge clk); k++;
    start32 = 1'b0;
    wait_done(k);
    check("ign.latency", k, 33);
    check("ign.quotient", q_o, 32'd333);
    check("ign.remainder", r_o, 32'd1);

    // Reset mid-operation aborts with no done
    launch(1'b0, 1'b0, 32'd500, 32'd9);
    k = 0;
    while (k < 5) begin @(negedge clk); k++; end
    a_in = 32'd42; b_in = 32'd6; start32 = 1'b1;
    @(negedge clk); k++;
    start32 = 1'b0;
    while (k < 10) begin @(negedge clk); k++; end
    rst = 1'b1;
    @(negedge clk);
    check("abort.busy_done", {30'd0, busy32, done32}, 32'd0);
    check("abort.q", q32, 32'd0);
    check("abort.r", r32, 32'd0);
    check("abort.dbz", {31'd0, dbz32}, 32'd0);
    rst = 1'b0;
    seen = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (done32 === 1'b1 || busy32 === 1'b1) seen++;
    end
    check("abort.no_activity", seen, 0);
    run("fresh",    1'b0, 1'b0, 32'd1000, 32'd3, 32'd333, 32'd1, 1'b0, 33);

    // Back-to-back: start held high through the done cycle (8-bit instance)
    @(negedge clk);
    sel8 = 1'b1; sm_in = 1'b0; a_in = 32'd200; b_in = 32'd7; start8 = 1'b1;
    @(negedge clk);
    k = 0;
    sm_in = 1'b1; a_in = 32'h9C; b_in = 32'h07;
    wait_done(k);
    check("b2b.lat1", k, 9);
    check("b2b.q1", q_o, 32'd28);
    check("b2b.r1", r_o, 32'd4);
    check("b2b.busy_done1", {31'd0, busy_o}, 32'd0);
    @(negedge clk);
    start8 = 1'b0;
    k = 0;
    check("b2b.done_single1", {31'd0, done_o}, 32'd0);
    check("b2b.accepted2", {31'd0, busy_o}, 32'd1);
    wait_done(k);
    check("b2b.lat2", k, 9);
    check("b2b.q2", q_o, 32'hF2);
    check("b2b.r2", r_o, 32'hFE);
    @(negedge clk);
    check("b2b.done_single2", {31'd0, done_o}, 32'd0);
    check("b2b.idle", {31'd0, busy_o}, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
